rst_sequencer: RTL and testbench



---
 rtl/rst_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_rst_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//
// Staged reset-release controller. Sits between the reset controller's
// active-low system reset output and the SoC reset domains. It holds every
// domain in reset for at least HOLD_CYCLES cycles after the request deasserts.
// It then releases the domains one at a time, domain 0 first, with a
// programmable gap between releases. A new reset request (or a software
// RESTART) re-asserts all domains together.
//
// A small bus-slave register file provides gap configuration, software
// re-sequencing and status. The register file is on the always-on reset
// rst_ib, so GAP survives software and fault resets.
//
// Register map (byte addresses):
//   0 CTRL 2B W  : bit0 = RESTART (write 1 to re-run the sequence)
//   2 GAP  2B RW : bits[CNT_WIDTH-1:0] = extra cycles between stage releases
//   4 STAT 4B R  : bits[STAGES-1:0] = rst_ob, bit8 = busy,
//                  bits[17:16] = state (HOLD=0, RELEASE=1, RUN=2)
//
// Ports:
//   clk        system clock
//   rst_ib     asynchronous active-low reset of this block
//   rst_req_b  synchronous active-low reset request
//   rst_ob     active-low per-domain resets, bit 0 released first
//   busy       high while the sequencer is not in RUN
//   addr       register byte address
//   w_rb       1 = write, 0 = read
//   acc        access size
//   rdata      registered read data
//   wdata      write data
//   req        bus request
//   resp       bus response, one cycle after an accepted request
//   fault      combinational, high for a request that is not a legal access
// -----------------------------------------------------------------------------

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module rst_sequencer #(
  parameter int STAGES      = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int DEFAULT_GAP = 4
) (
  input  logic                      clk,
  input  logic                      rst_ib,
  input  logic                      rst_req_b,
  output logic [STAGES-1:0]         rst_ob,
  output logic                      busy,
  input  logic [2:0]                addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     rdata,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic                      resp,
  output logic                      fault
);

  localparam int BW    = `BUS_WIDTH;
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_RST   = CNT_WIDTH'(DEFAULT_GAP);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(STAGES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [STAGES-1:0]      rst_ob_reg;
  logic                   busy_reg;
  logic [CNT_WIDTH-1:0]   gap_reg;
  logic                   resp_reg;
  logic [BW-1:0]          rdata_reg;
  logic [BW-1:0]          rdata_next;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic sel_ctrl;
  logic sel_gap;
  logic sel_stat;
  logic invalid;
  logic valid_acc;
  logic wr_gap;
  logic restart;
  logic abort;

  assign sel_ctrl = (addr == 3'd0);
  assign sel_gap  = (addr == 3'd2);
  assign sel_stat = (addr == 3'd4);

  // Anything not explicitly legal is a fault: unknown address, wrong size,
  // reading the write-only CTRL, or writing the read-only STAT.
  always_comb begin
    invalid = 1'b1;
    if (sel_ctrl) begin
      invalid = (acc != `BUS_ACC_2B) || !w_rb;
    end else if (sel_gap) begin
      invalid = (acc != `BUS_ACC_2B);
    end else if (sel_stat) begin
      invalid = (acc != `BUS_ACC_4B) || w_rb;
    end
  end

  assign valid_acc = req & ~invalid;
  assign fault     = req & invalid;
  assign wr_gap    = valid_acc & w_rb & sel_gap;
  assign restart   = valid_acc & w_rb & sel_ctrl & wdata[0];

  // The external request and a software RESTART both force the whole
  // sequence back to HOLD; the external request wins trivially since both
  // lead to the same place, and register writes are applied independently.
  assign abort = ~rst_req_b | restart;

  // Only the low CNT_WIDTH bits of write data are ever stored.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[BW-1:CNT_WIDTH]};

  // ---------------------------------------------------------------------------
  // Status word and read mux
  // ---------------------------------------------------------------------------
  logic [BW-1:0] stat_word;

  always_comb begin
    stat_word                = '0;
    stat_word[STAGES-1:0]    = rst_ob_reg;
    stat_word[8]             = busy_reg;
    stat_word[17:16]         = state_reg;
  end

  always_comb begin
    rdata_next = rdata_reg;
    if (valid_acc && !w_rb) begin
      rdata_next = sel_gap ? BW'(gap_reg) : stat_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Next release pattern: shift one more deasserted bit in from the bottom.
  // Because the pattern only ever grows upward, domains can never be released
  // out of order.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] release_next;

  assign release_next[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_release
      assign release_next[gi] = rst_ob_reg[gi-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Bus-side registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_ib) begin
    if (!rst_ib) begin
      gap_reg   <= GAP_RST;
      resp_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      resp_reg  <= valid_acc;
      rdata_reg <= rdata_next;
      if (wr_gap) begin
        gap_reg <= wdata[CNT_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_ib) begin
    if (!rst_ib) begin
      state_reg  <= ST_HOLD;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      rst_ob_reg <= '0;
      busy_reg   <= 1'b1;
    end else if (abort) begin
      // All domains assert together; there is never a partial assert.
      state_reg  <= ST_HOLD;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      rst_ob_reg <= '0;
      busy_reg   <= 1'b1;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          rst_ob_reg <= '0;
          busy_reg   <= 1'b1;
          if (cnt_reg == HOLD_LAST) begin
            cnt_reg    <= '0;
            idx_reg    <= '0;
            rst_ob_reg <= release_next;
            if (STAGES == 1) begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ST_RELEASE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_RELEASE: begin
          // GAP is compared live, and with >= so that shrinking GAP below
          // the running count advances on the very next edge.
          if (cnt_reg >= gap_reg) begin
            cnt_reg    <= '0;
            idx_reg    <= idx_reg + 1'b1;
            rst_ob_reg <= release_next;
            if ((idx_reg + 1'b1) == LAST_IDX) begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_RUN: begin
          rst_ob_reg <= '1;
          busy_reg   <= 1'b0;
        end

        default: begin
          state_reg  <= ST_HOLD;
          cnt_reg    <= '0;
          idx_reg    <= '0;
          rst_ob_reg <= '0;
          busy_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign rst_ob = rst_ob_reg;
  assign busy   = busy_reg;
  assign resp   = resp_reg;
  assign rdata  = rdata_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_rst_sequencer;

  localparam int STAGES      = 4;
  localparam int CNT_WIDTH   = 8;
  localparam int HOLD_CYCLES = 16;
  localparam int DEFAULT_GAP = 4;

  logic        clk = 1'b0;
  logic        rst_ib;
  logic        rst_req_b;
  logic [3:0]  rst_ob;
  logic        busy;
  logic [2:0]  addr;
  logic        w_rb;
  logic [1:0]  acc;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        req;
  logic        resp;
  logic        fault;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  rst_sequencer #(
    .STAGES      (STAGES),
    .CNT_WIDTH   (CNT_WIDTH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .DEFAULT_GAP (DEFAULT_GAP)
  ) dut (
    .clk       (clk),
    .rst_ib    (rst_ib),
    .rst_req_b (rst_req_b),
    .rst_ob    (rst_ob),
    .busy      (busy),
    .addr      (addr),
    .w_rb      (w_rb),
    .acc       (acc),
    .rdata     (rdata),
    .wdata     (wdata),
    .req       (req),
    .resp      (resp),
    .fault     (fault)
  );

  // Expected domain pattern k edges after the abort edge (k=0 is the abort
  // edge itself), with a constant gap.
  function automatic logic [3:0] exp_ob(input int k, input int gap);
    int n;
    if (k < HOLD_CYCLES) n = 0;
    else n = 1 + (k - HOLD_CYCLES) / (gap + 1);
    if (n > STAGES) n = STAGES;
    return 4'((1 << n) - 1);
  endfunction

  // Pattern for the mid-release GAP change: 10 -> 3 written on edge 23.
  function automatic logic [3:0] exp_ob_t5(input int k);
    if (k < 16) return 4'h0;
    if (k < 24) return 4'h1;
    if (k < 28) return 4'h3;
    if (k < 32) return 4'h7;
    return 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int k, input logic [3:0] eob);
    tick();
    chk({tag, ".rst_ob"}, 32'(rst_ob), 32'(eob));
    chk({tag, ".busy"}, 32'(busy), 32'(eob != 4'hF));
    $display("step %s k=%0d rst_ob=%b busy=%b", tag, k, rst_ob, busy);
  endtask

  // One bus transaction. Read expectations go into the scoreboard on issue and
  // are popped when the response comes back.
  task automatic bus(input string tag, input logic [2:0] a, input logic w,
                     input logic [1:0] ac, input logic [31:0] wd,
                     input logic ok, input logic [31:0] exp_rd);
    addr  = a;
    w_rb  = w;
    acc   = ac;
    wdata = wd;
    req   = 1'b1;
    if (ok && !w) exp_q.push_back(exp_rd);
    #1;
    chk({tag, ".fault"}, 32'(fault), 32'(!ok));
    @(posedge clk);
    #1;
    req   = 1'b0;
    w_rb  = 1'b0;
    wdata = '0;
    chk({tag, ".resp"}, 32'(resp), 32'(ok));
    if (!ok) begin
      chk({tag, ".rdata_hold"}, rdata, last_rdata);
    end else if (!w) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s.scoreboard: observed read response, expected nothing queued", tag);
      end else begin
        last_rdata = exp_q.pop_front();
        chk({tag, ".rdata"}, rdata, last_rdata);
      end
    end
    $display("bus %s addr=%0d w=%b acc=%0d wdata=0x%08h resp=%b rdata=0x%08h",
             tag, a, w, ac, wd, resp, rdata);
  endtask

  initial begin
    rst_ib     = 1'b1;
    rst_req_b  = 1'b1;
    req        = 1'b0;
    addr       = 3'd6;
    w_rb       = 1'b0;
    acc        = `BUS_ACC_2B;
    wdata      = '0;
    last_rdata = '0;

    // Async reset, checked before any clock edge sees it.
    #2 rst_ib = 1'b0;
    #1;
    chk("rst.rst_ob", 32'(rst_ob), 32'h0);
    chk("rst.busy",   32'(busy),   32'h1);
    chk("rst.resp",   32'(resp),   32'h0);
    chk("rst.rdata",  rdata,       32'h0);
    chk("idle.fault", 32'(fault),  32'h0);
    $display("reset applied rst_ob=%b busy=%b", rst_ob, busy);
    repeat (2) @(posedge clk);
    #1 rst_ib = 1'b1;

    // Power-on sequence with default gap.
    for (int k = 1; k <= 32; k++) step("t1", k, exp_ob(k, DEFAULT_GAP));
    bus("t1.stat", 3'd4, 1'b0, `BUS_ACC_4B, 32'h0, 1'b1, 32'h0002000F);
    bus("t1.gap",  3'd2, 1'b0, `BUS_ACC_2B, 32'h0, 1'b1, 32'h4);

    // GAP=0, no-op CTRL write, then RESTART.
    bus("t2.wgap", 3'd2, 1'b1, `BUS_ACC_2B, 32'hFF00, 1'b1, 32'h0);
    bus("t2.rgap", 3'd2, 1'b0, `BUS_ACC_2B, 32'h0, 1'b1, 32'h0);
    bus("t2.ctrl0", 3'd0, 1'b1, `BUS_ACC_2B, 32'h0, 1'b1, 32'h0);
    chk("t2.ctrl0.rst_ob", 32'(rst_ob), 32'hF);
    bus("t2.restart", 3'd0, 1'b1, `BUS_ACC_2B, 32'h1, 1'b1, 32'h0);
    chk("t2.abort.rst_ob", 32'(rst_ob), 32'h0);
    chk("t2.abort.busy",   32'(busy),   32'h1);
    for (int k = 1; k <= 22; k++) step("t2", k, exp_ob(k, 0));

    // Illegal accesses in RUN: fault, no response, nothing changes.
    bus("t4.rd0_4b",  3'd0, 1'b0, `BUS_ACC_4B, 32'h0, 1'b0, 32'h0);
    bus("t4.acc4_2b", 3'd4, 1'b0, `BUS_ACC_2B, 32'h0, 1'b0, 32'h0);
    bus("t4.wr4",     3'd4, 1'b1, `BUS_ACC_4B, 32'h1, 1'b0, 32'h0);
    bus("t4.rd0",     3'd0, 1'b0, `BUS_ACC_2B, 32'h0, 1'b0, 32'h0);
    bus("t4.addr6",   3'd6, 1'b0, `BUS_ACC_2B, 32'h0, 1'b0, 32'h0);
    bus("t4.wgap4b",  3'd2, 1'b1, `BUS_ACC_4B, 32'h55, 1'b0, 32'h0);
    bus("t4.rst1b",   3'd0, 1'b1, `BUS_ACC_1B, 32'h1, 1'b0, 32'h0);
    chk("t4.rst_ob", 32'(rst_ob), 32'hF);
    chk("t4.busy",   32'(busy),   32'h0);
    bus("t4.rgap", 3'd2, 1'b0, `BUS_ACC_2B, 32'h0, 1'b1, 32'h0);

    // rst_req_b pulse while two domains are released.
    bus("t3.wgap", 3'd2, 1'b1, `BUS_ACC_2B, 32'h4, 1'b1, 32'h0);
    bus("t3.restart", 3'd0, 1'b1, `BUS_ACC_2B, 32'h1, 1'b1, 32'h0);
    chk("t3.k0.rst_ob", 32'(rst_ob), 32'h0);
    bus("t3.stat_hold", 3'd4, 1'b0, `BUS_ACC_4B, 32'h0, 1'b1, 32'h00000100);
    for (int k = 2; k <= 22; k++) step("t3a", k, exp_ob(k, 4));
    rst_req_b = 1'b0;
    step("t3.abort", 0, 4'h0);
    rst_req_b = 1'b1;
    for (int k = 1; k <= 32; k++) step("t3b", k, exp_ob(k, 4));

    // Shrinking GAP mid-release.
    bus("t5.wgap10", 3'd2, 1'b1, `BUS_ACC_2B, 32'd10, 1'b1, 32'h0);
    bus("t5.restart", 3'd0, 1'b1, `BUS_ACC_2B, 32'h1, 1'b1, 32'h0);
    for (int k = 1; k <= 22; k++) step("t5a", k, exp_ob_t5(k));
    bus("t5.wgap3", 3'd2, 1'b1, `BUS_ACC_2B, 32'd3, 1'b1, 32'h0);
    chk("t5.k23.rst_ob", 32'(rst_ob), 32'(exp_ob_t5(23)));
    for (int k = 24; k <= 34; k++) step("t5b", k, exp_ob_t5(k));

    // Request low together with bus writes.
    rst_req_b = 1'b0;
    bus("t6.wgap7", 3'd2, 1'b1, `BUS_ACC_2B, 32'd7, 1'b1, 32'h0);
    chk("t6.rst_ob", 32'(rst_ob), 32'h0);
    chk("t6.busy",   32'(busy),   32'h1);
    bus("t6.restart", 3'd0, 1'b1, `BUS_ACC_2B, 32'h1, 1'b1, 32'h0);
    chk("t6.restart.rst_ob", 32'(rst_ob), 32'h0);
    rst_req_b = 1'b1;
    bus("t6.rgap", 3'd2, 1'b0, `BUS_ACC_2B, 32'h0, 1'b1, 32'd7);
    for (int k = 2; k <= 19; k++) step("t6a", k, exp_ob(k, 7));
    bus("t6.stat_rel", 3'd4, 1'b0, `BUS_ACC_4B, 32'h0, 1'b1, 32'h00010101);
    for (int k = 21; k <= 40; k++) step("t6b", k, exp_ob(k, 7));
    bus("t6.stat_run", 3'd4, 1'b0, `BUS_ACC_4B, 32'h0, 1'b1, 32'h0002000F);

    chk("end.queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
